// File: rtl/spirxdata_if.sv
// spirxdata_if: byte-level SPI port plus block-buffer write port shared by
// the SD-card SPI data engines. The engine side uses the master modport;
// the SPI byte driver and buffer memory side use the slave modport.
interface spirxdata_if #(
    parameter int DW = 32,
    parameter int AW = 8
);
    logic          o_write;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_data;
    logic          i_ll_busy;
    logic          o_ll_stb;
    logic [7:0]    o_ll_byte;
    logic          i_ll_stb;
    logic [7:0]    i_ll_byte;

    modport master (
        output o_write, o_addr, o_data, o_ll_stb, o_ll_byte,
        input  i_ll_busy, i_ll_stb, i_ll_byte
    );

    modport slave (
        input  o_write, o_addr, o_data, o_ll_stb, o_ll_byte,
        output i_ll_busy, i_ll_stb, i_ll_byte
    );
endinterface

// File: rtl/spirxdata.sv
// spirxdata: SPI-mode SD receive data engine. Clocks 0xFF filler out, waits
// for the start token, packs the block into DW-bit words for the buffer
// memory and verifies the trailing CRC16-CCITT.
module spirxdata #(
    parameter int   DW                = 32,
    parameter int   AW                = 8,
    parameter logic OPT_LITTLE_ENDIAN = 1'b0,
    parameter int   LGTIMEOUT         = 16
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic [3:0]  i_lgblksz,
    input  logic        i_fifo,
    output logic        o_busy,
    spirxdata_if.master bus,
    output logic        o_done,
    output logic        o_crcerr,
    output logic        o_tokerr,
    output logic        o_timeout,
    output logic [7:0]  o_response
);
    localparam int BPW = DW / 8;
    localparam int WBW = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [1:0] {S_IDLE, S_TOKEN, S_DATA, S_CRC} state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 pending;
    logic [LGTIMEOUT-1:0] wait_cnt;
    logic [9:0]           byte_cnt;
    logic [WBW-1:0]       word_cnt;
    logic [DW-1:0]        word;
    logic [15:0]          crc;
    logic [7:0]           crc_hi;
    logic                 crc_second;
    logic [3:0]           lgblksz_r;

    logic                 start_ok;
    logic                 finish;
    logic                 tok_good;
    logic                 tok_err_byte;
    logic                 last_data;
    logic                 word_full;
    logic [9:0]           blk_last;
    logic [DW-1:0]        word_nxt;
    logic [3:0]           lgblksz_clamped;

    // One full byte of CRC16-CCITT (poly 0x1021), MSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int k = 7; k >= 0; k--) begin
            if (r[15] ^ b[k])
                r = {r[14:0], 1'b0} ^ 16'h1021;
            else
                r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    // The filler byte never changes; the card only cares about the clocks.
    assign bus.o_ll_byte = 8'hff;

    // Byte classification, word assembly and next-state decode.
    always_comb begin
        start_ok     = (state == S_IDLE) && i_start && !o_done;
        tok_good     = (bus.i_ll_byte == 8'hfe);
        tok_err_byte = (bus.i_ll_byte[7:4] == 4'h0) && (bus.i_ll_byte != 8'h00);
        blk_last     = (10'd1 << lgblksz_r) - 10'd1;
        last_data    = (byte_cnt == blk_last);
        word_full    = (word_cnt == WBW'(BPW - 1));
        if (OPT_LITTLE_ENDIAN)
            word_nxt = (word >> 8) | (DW'(bus.i_ll_byte) << (DW - 8));
        else
            word_nxt = (word << 8) | DW'(bus.i_ll_byte);
        if (i_lgblksz < 4'd2)
            lgblksz_clamped = 4'd2;
        else if (i_lgblksz > 4'd9)
            lgblksz_clamped = 4'd9;
        else
            lgblksz_clamped = i_lgblksz;

        state_nxt = state;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok)
                    state_nxt = S_TOKEN;
            end
            S_TOKEN: begin
                if (bus.i_ll_stb) begin
                    if (tok_good) begin
                        state_nxt = S_DATA;
                    end else if (tok_err_byte || (&wait_cnt)) begin
                        state_nxt = S_IDLE;
                        finish    = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (bus.i_ll_stb && last_data)
                    state_nxt = S_CRC;
            end
            S_CRC: begin
                if (bus.i_ll_stb && crc_second) begin
                    state_nxt = S_IDLE;
                    finish    = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Keep exactly one byte request in flight while a transfer is active.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pending      <= 1'b0;
            bus.o_ll_stb <= 1'b0;
        end else if (bus.o_ll_stb && !bus.i_ll_busy) begin
            pending      <= 1'b1;
            bus.o_ll_stb <= 1'b0;
        end else begin
            if (bus.i_ll_stb)
                pending <= 1'b0;
            if ((state != S_IDLE) && !pending && !bus.o_ll_stb)
                bus.o_ll_stb <= 1'b1;
        end
    end

    // Token wait, word packing, memory writes, CRC check and status.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_crcerr    <= 1'b0;
            o_tokerr    <= 1'b0;
            o_timeout   <= 1'b0;
            o_response  <= 8'h00;
            bus.o_write <= 1'b0;
            bus.o_addr  <= '0;
            bus.o_data  <= '0;
            wait_cnt    <= '0;
            byte_cnt    <= '0;
            word_cnt    <= '0;
            word        <= '0;
            crc         <= '0;
            crc_hi      <= '0;
            crc_second  <= 1'b0;
            lgblksz_r   <= 4'd2;
        end else begin
            o_done      <= finish;
            bus.o_write <= 1'b0;
            if (finish)
                o_busy <= 1'b0;
            if (bus.o_write)
                bus.o_addr[AW-2:0] <= bus.o_addr[AW-2:0] + (AW-1)'(1);
            if (start_ok) begin
                o_busy     <= 1'b1;
                bus.o_addr <= {i_fifo, {(AW-1){1'b0}}};
                lgblksz_r  <= lgblksz_clamped;
                o_crcerr   <= 1'b0;
                o_tokerr   <= 1'b0;
                o_timeout  <= 1'b0;
                wait_cnt   <= '0;
                byte_cnt   <= '0;
                word_cnt   <= '0;
                word       <= '0;
                crc        <= '0;
                crc_second <= 1'b0;
            end
            if (bus.i_ll_stb) begin
                case (state)
                    S_TOKEN: begin
                        if (tok_good) begin
                            o_response <= bus.i_ll_byte;
                        end else if (tok_err_byte) begin
                            o_response <= bus.i_ll_byte;
                            o_tokerr   <= 1'b1;
                        end else if (&wait_cnt) begin
                            o_timeout <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + LGTIMEOUT'(1);
                        end
                    end
                    S_DATA: begin
                        word     <= word_nxt;
                        crc      <= crc16_byte(crc, bus.i_ll_byte);
                        byte_cnt <= byte_cnt + 10'd1;
                        if (word_full) begin
                            word_cnt    <= '0;
                            bus.o_write <= 1'b1;
                            bus.o_data  <= word_nxt;
                        end else begin
                            word_cnt <= word_cnt + WBW'(1);
                        end
                    end
                    S_CRC: begin
                        if (!crc_second) begin
                            crc_hi     <= bus.i_ll_byte;
                            crc_second <= 1'b1;
                        end else if ({crc_hi, bus.i_ll_byte} != crc) begin
                            o_crcerr <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spirxdata.sv
// tb_spirxdata: table-driven bench for the SPI receive data engine. Two
// copies of the engine (big- and little-endian packing) see the same card
// byte stream; a card responder answers byte requests and a write
// scoreboard compares every buffer write with the bench model.
module tb_spirxdata;
    localparam int DW = 32;
    localparam int AW = 8;

    typedef struct {
        logic [3:0] lgblksz;
        logic       fifo;
        int         n_ff;
        bit         has_token;
        logic [7:0] token;
        int         nbytes;
        logic [7:0] data_base;
        bit         rand_data;
        logic [7:0] crc_xor;
        bit         rand_busy;
        logic       e_tokerr;
        logic       e_timeout;
        logic       e_crcerr;
        logic [7:0] e_resp;
        int         e_writes;
        int         e_reqs;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] be;
        logic [DW-1:0] le;
    } wr_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] lgblksz;
    logic       fifo;
    logic       ll_busy;
    logic       ll_stb;
    logic [7:0] ll_byte;

    logic       busy_be, done_be, crcerr_be, tokerr_be, timeout_be;
    logic [7:0] resp_be;
    logic       busy_le, done_le, crcerr_le, tokerr_le, timeout_le;
    logic [7:0] resp_le;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_stb_cyc = 0;
    int         write_count = 0;
    int         done_count = 0;
    int         req_count = 0;
    int         outstanding = 0;
    int         resp_cnt = 0;
    int         wr_base = 0;
    int         done_base = 0;
    int         req_base = 0;
    bit         rand_busy = 1'b0;
    logic [7:0] rx_q[$];
    wr_t        exp_q[$];
    vec_t       vecs[7];

    spirxdata_if #(.DW(DW), .AW(AW)) bus_be ();
    spirxdata_if #(.DW(DW), .AW(AW)) bus_le ();

    assign bus_be.i_ll_busy = ll_busy;
    assign bus_be.i_ll_stb  = ll_stb;
    assign bus_be.i_ll_byte = ll_byte;
    assign bus_le.i_ll_busy = ll_busy;
    assign bus_le.i_ll_stb  = ll_stb;
    assign bus_le.i_ll_byte = ll_byte;

    spirxdata #(.DW(DW), .AW(AW), .OPT_LITTLE_ENDIAN(1'b0), .LGTIMEOUT(4)) dut_be (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_lgblksz(lgblksz),
        .i_fifo(fifo), .o_busy(busy_be), .bus(bus_be), .o_done(done_be),
        .o_crcerr(crcerr_be), .o_tokerr(tokerr_be), .o_timeout(timeout_be),
        .o_response(resp_be)
    );

    spirxdata #(.DW(DW), .AW(AW), .OPT_LITTLE_ENDIAN(1'b1), .LGTIMEOUT(4)) dut_le (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_lgblksz(lgblksz),
        .i_fifo(fifo), .o_busy(busy_le), .bus(bus_le), .o_done(done_le),
        .o_crcerr(crcerr_le), .o_tokerr(tokerr_le), .o_timeout(timeout_le),
        .o_response(resp_le)
    );

    // 100 MHz clock and a cycle counter used for latency checks.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Table-free CRC16-CCITT byte update (XMODEM form, init 0).
    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] x;
        x = {8'h00, c[15:8] ^ b};
        x = x ^ (x >> 4);
        return (c << 8) ^ (x << 12) ^ (x << 5) ^ x;
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Card model: answers each accepted request two cycles later with the
    // next queued byte (0xFF once the queue runs dry).
    initial begin
        ll_stb  = 1'b0;
        ll_byte = 8'h00;
        ll_busy = 1'b0;
        forever begin
            @(negedge clk);
            ll_stb = 1'b0;
            if (!rst_n) begin
                resp_cnt    = 0;
                outstanding = 0;
                ll_busy     = 1'b0;
                rx_q.delete();
            end else begin
                if (resp_cnt > 0) begin
                    resp_cnt--;
                    if (resp_cnt == 0) begin
                        ll_stb = 1'b1;
                        if (rx_q.size() > 0)
                            ll_byte = rx_q.pop_front();
                        else
                            ll_byte = 8'hff;
                        outstanding--;
                        last_stb_cyc = cyc;
                    end
                end
                ll_busy = rand_busy ? 1'($urandom_range(0, 1)) : 1'b0;
                if (bus_be.o_ll_stb && !ll_busy) begin
                    compare("single_outstanding", 32'(outstanding), 32'd0);
                    outstanding++;
                    req_count++;
                    resp_cnt = 2;
                end
            end
        end
    end

    // Write scoreboard and done-pulse counter.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus_be.o_write) begin
                write_count++;
                if (exp_q.size() == 0) begin
                    compare("write_was_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    compare("wr_addr_be", 32'(bus_be.o_addr), 32'(e.addr));
                    compare("wr_data_be", bus_be.o_data, e.be);
                    compare("wr_strobe_le", 32'(bus_le.o_write), 32'd1);
                    compare("wr_addr_le", 32'(bus_le.o_addr), 32'(e.addr));
                    compare("wr_data_le", bus_le.o_data, e.le);
                end
            end
            if (done_be)
                done_count++;
        end
    end

    task automatic checkResetValues(input string tag);
        compare({tag, "_busy"},     32'(busy_be),          32'd0);
        compare({tag, "_write"},    32'(bus_be.o_write),   32'd0);
        compare({tag, "_ll_stb"},   32'(bus_be.o_ll_stb),  32'd0);
        compare({tag, "_done"},     32'(done_be),          32'd0);
        compare({tag, "_crcerr"},   32'(crcerr_be),        32'd0);
        compare({tag, "_tokerr"},   32'(tokerr_be),        32'd0);
        compare({tag, "_timeout"},  32'(timeout_be),       32'd0);
        compare({tag, "_addr"},     32'(bus_be.o_addr),    32'd0);
        compare({tag, "_data"},     bus_be.o_data,         32'd0);
        compare({tag, "_response"}, 32'(resp_be),          32'd0);
        compare({tag, "_ll_byte"},  32'(bus_be.o_ll_byte), 32'hff);
        compare({tag, "_le_data"},  bus_le.o_data,         32'd0);
        compare({tag, "_le_busy"},  32'(busy_le),          32'd0);
    endtask

    // Queue the card's byte stream and expected writes, then start a block.
    task automatic applyStimulus(input vec_t v);
        logic [7:0] d[$];
        logic [7:0] b;
        logic [15:0] c;
        wr_t w;
        rand_busy = v.rand_busy;
        for (int i = 0; i < v.n_ff; i++)
            rx_q.push_back(8'hff);
        if (v.has_token)
            rx_q.push_back(v.token);
        if (v.has_token && v.token == 8'hfe) begin
            c = 16'h0000;
            for (int i = 0; i < v.nbytes; i++) begin
                b = v.rand_data ? 8'($urandom) : 8'(v.data_base + 8'(i));
                d.push_back(b);
                rx_q.push_back(b);
                c = crc_model(c, b);
            end
            rx_q.push_back(c[15:8]);
            rx_q.push_back(c[7:0] ^ v.crc_xor);
            for (int wi = 0; wi < v.nbytes / 4; wi++) begin
                w.addr = {v.fifo, 7'(wi)};
                w.be   = {d[4*wi], d[4*wi+1], d[4*wi+2], d[4*wi+3]};
                w.le   = {d[4*wi+3], d[4*wi+2], d[4*wi+1], d[4*wi]};
                exp_q.push_back(w);
            end
        end
        wr_base   = write_count;
        done_base = done_count;
        req_base  = req_count;
        @(negedge clk);
        start   = 1'b1;
        lgblksz = v.lgblksz;
        fifo    = v.fifo;
        @(negedge clk);
        start = 1'b0;
        compare("busy_after_start", 32'(busy_be), 32'd1);
        compare("no_stb_yet", 32'(bus_be.o_ll_stb), 32'd0);
        @(negedge clk);
        compare("first_stb", 32'(bus_be.o_ll_stb), 32'd1);
    endtask

    // Wait for the end of the block and compare status and totals.
    task automatic checkOutput(input vec_t v);
        int waited;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!done_be && waited < 6000);
        compare("done_seen", 32'(done_be), 32'd1);
        compare("done_latency", 32'(cyc - last_stb_cyc), 32'd1);
        compare("busy_at_done", 32'(busy_be), 32'd0);
        compare("done_le", 32'(done_le), 32'd1);
        compare("tokerr", 32'(tokerr_be), 32'(v.e_tokerr));
        compare("timeout", 32'(timeout_be), 32'(v.e_timeout));
        compare("crcerr", 32'(crcerr_be), 32'(v.e_crcerr));
        compare("crcerr_le", 32'(crcerr_le), 32'(v.e_crcerr));
        compare("response", 32'(resp_be), 32'(v.e_resp));
        rand_busy = 1'b0;
        repeat (4) @(negedge clk);
        compare("done_once", 32'(done_count - done_base), 32'd1);
        compare("write_total", 32'(write_count - wr_base), 32'(v.e_writes));
        compare("request_total", 32'(req_count - req_base), 32'(v.e_reqs));
        compare("writes_left", 32'(exp_q.size()), 32'd0);
        compare("idle_ll_stb", 32'(bus_be.o_ll_stb), 32'd0);
        exp_q.delete();
        rx_q.delete();
    endtask

    // Safety net: never let a broken design hang the run.
    initial begin
        #800000;
        $display("[TB] FAIL watchdog: run did not complete, %0d checks so far", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, vector table, then hand-written corner cases.
    initial begin
        vec_t v;
        int   waited;
        int   nwr;

        //          lg    fifo  nff tok   token  nb   base   rd    xor    rbsy  tok   tmo   crc   resp   wr   req
        vecs[0] = '{4'd3,  1'b0, 2,  1'b1, 8'hfe, 8,   8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hfe, 2,   13};
        vecs[1] = '{4'd3,  1'b0, 2,  1'b1, 8'hfe, 8,   8'h01, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 8'hfe, 2,   13};
        vecs[2] = '{4'd3,  1'b0, 2,  1'b1, 8'h05, 0,   8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 0,   3};
        vecs[3] = '{4'd3,  1'b0, 16, 1'b0, 8'h00, 0,   8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 0,   16};
        vecs[4] = '{4'd0,  1'b1, 0,  1'b1, 8'hfe, 4,   8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hfe, 1,   7};
        vecs[5] = '{4'd9,  1'b1, 1,  1'b1, 8'hfe, 512, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hfe, 128, 516};
        vecs[6] = '{4'd15, 1'b0, 0,  1'b1, 8'hfe, 512, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hfe, 128, 515};

        rst_n   = 1'b0;
        start   = 1'b0;
        lgblksz = 4'd0;
        fifo    = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            $display("[TB] vector %0d", i);
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
        end

        // Start request coinciding with o_done must be ignored.
        $display("[TB] start during done");
        v = '{4'd3, 1'b0, 1, 1'b1, 8'h09, 0, 8'h00, 1'b0, 8'h00, 1'b0,
              1'b1, 1'b0, 1'b0, 8'h09, 0, 2};
        applyStimulus(v);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!done_be && waited < 200);
        compare("sdd_done_seen", 32'(done_be), 32'd1);
        compare("sdd_tokerr", 32'(tokerr_be), 32'd1);
        compare("sdd_response", 32'(resp_be), 32'h09);
        start   = 1'b1;
        lgblksz = 4'd3;
        @(negedge clk);
        start = 1'b0;
        compare("sdd_busy_stays_low", 32'(busy_be), 32'd0);
        compare("sdd_tokerr_held", 32'(tokerr_be), 32'd1);
        repeat (4) @(negedge clk);
        compare("sdd_no_new_requests", 32'(req_count - req_base), 32'd2);
        rx_q.delete();

        // Little-endian packing, then reset in the middle of the block.
        $display("[TB] reset mid-transfer");
        v = '{4'd9, 1'b0, 0, 1'b1, 8'hfe, 512, 8'ha0, 1'b0, 8'h00, 1'b0,
              1'b0, 1'b0, 1'b0, 8'hfe, 0, 0};
        applyStimulus(v);
        nwr    = 0;
        waited = 0;
        while (nwr < 5 && waited < 2000) begin
            @(negedge clk);
            waited++;
            if (bus_be.o_write) begin
                if (nwr == 0) begin
                    compare("first_word_le", bus_le.o_data, 32'ha3a2a1a0);
                    compare("first_word_be", bus_be.o_data, 32'ha0a1a2a3);
                end
                nwr++;
            end
        end
        compare("words_before_reset", 32'(nwr), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("midreset");
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        compare("no_writes_after_reset", 32'(write_count - wr_base), 32'd5);
        compare("no_done_after_reset", 32'(done_count - done_base), 32'd0);
        compare("idle_after_reset", 32'(busy_be), 32'd0);
        compare("no_stb_after_reset", 32'(bus_be.o_ll_stb), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
